// File: rtl/pipeline_stall_controller_if.sv
// Control bundle between the stall sequencer and the pipeline/SRAM side.
// The master drives the stage controls, the SRAM request and the debug/perf outputs.
interface pipeline_stall_controller_if #(
  parameter int CNT_W = 16
);
  logic             hazard_detected;
  logic             Branch_taken;
  logic             Mem_R_EN;
  logic             Mem_W_EN;
  logic             sram_ready;
  logic             sram_req;
  logic             freeze_IF;
  logic             flush_IF_ID;
  logic             bubble_ID_EXE;
  logic             freeze_pipe;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;
  logic [1:0]       state;

  modport master (
    input  hazard_detected, Branch_taken, Mem_R_EN, Mem_W_EN, sram_ready,
    output sram_req, freeze_IF, flush_IF_ID, bubble_ID_EXE, freeze_pipe,
           mem_timeout, stall_count, flush_count, state
  );

  modport slave (
    output hazard_detected, Branch_taken, Mem_R_EN, Mem_W_EN, sram_ready,
    input  sram_req, freeze_IF, flush_IF_ID, bubble_ID_EXE, freeze_pipe,
           mem_timeout, stall_count, flush_count, state
  );
endinterface

// File: rtl/pipeline_stall_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: merges hazard, branch and SRAM
// wait events into freeze/flush/bubble controls, owns the SRAM handshake and perf counters.
module pipeline_stall_controller #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 64
) (
  input logic                         clk,
  input logic                         rst,
  pipeline_stall_controller_if.master bus
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    ABORT    = 2'b10
  } state_t;

  localparam logic [7:0]       WAIT_LAST = 8'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1'b1);

  state_t           state_r;
  state_t           next_state_s;
  logic [7:0]       wait_cnt_r;
  logic [7:0]       wait_cnt_next_s;
  logic             mem_timeout_r;
  logic [CNT_W-1:0] stall_count_r;
  logic [CNT_W-1:0] flush_count_r;

  logic             mem_op_s;
  logic             sram_req_s;
  logic             freeze_if_s;
  logic             flush_s;
  logic             bubble_s;
  logic             freeze_pipe_s;
  logic             timeout_set_s;

  // Unfrozen-cycle controls {freeze_IF, flush_IF_ID, bubble_ID_EXE}; a taken branch
  // wins over a hazard because the hazarding instruction is on the wrong path.
  function automatic logic [2:0] advance_ctl(input logic branch, input logic hazard);
    logic [2:0] ctl;
    if (branch) begin
      ctl = 3'b011;
    end else if (hazard) begin
      ctl = 3'b101;
    end else begin
      ctl = 3'b000;
    end
    return ctl;
  endfunction

  assign mem_op_s = bus.Mem_R_EN | bus.Mem_W_EN;

  // Next-state, wait watchdog and per-cycle stage controls.
  always_comb begin
    next_state_s    = state_r;
    wait_cnt_next_s = wait_cnt_r;
    sram_req_s      = 1'b0;
    freeze_if_s     = 1'b0;
    flush_s         = 1'b0;
    bubble_s        = 1'b0;
    freeze_pipe_s   = 1'b0;
    timeout_set_s   = 1'b0;
    case (state_r)
      RUN: begin
        if (mem_op_s) begin
          freeze_pipe_s   = 1'b1;
          freeze_if_s     = 1'b1;
          next_state_s    = MEM_WAIT;
          wait_cnt_next_s = 8'd0;
        end else begin
          {freeze_if_s, flush_s, bubble_s} = advance_ctl(bus.Branch_taken, bus.hazard_detected);
          next_state_s = RUN;
        end
      end
      MEM_WAIT: begin
        sram_req_s = 1'b1;
        if (!bus.sram_ready) begin
          // Frozen cycle: branch/hazard wait for the first unfrozen cycle.
          freeze_pipe_s   = 1'b1;
          freeze_if_s     = 1'b1;
          wait_cnt_next_s = wait_cnt_r + 8'd1;
          if (wait_cnt_r == WAIT_LAST) begin
            next_state_s  = ABORT;
            timeout_set_s = 1'b1;
          end else begin
            next_state_s = MEM_WAIT;
          end
        end else begin
          {freeze_if_s, flush_s, bubble_s} = advance_ctl(bus.Branch_taken, bus.hazard_detected);
          next_state_s = RUN;
        end
      end
      ABORT: begin
        {freeze_if_s, flush_s, bubble_s} = advance_ctl(bus.Branch_taken, bus.hazard_detected);
        next_state_s    = RUN;
        wait_cnt_next_s = 8'd0;
      end
      default: begin
        next_state_s    = RUN;
        wait_cnt_next_s = 8'd0;
      end
    endcase
  end

  // State, watchdog counter and sticky timeout flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= RUN;
      wait_cnt_r    <= 8'd0;
      mem_timeout_r <= 1'b0;
    end else begin
      state_r       <= next_state_s;
      wait_cnt_r    <= wait_cnt_next_s;
      mem_timeout_r <= mem_timeout_r | timeout_set_s;
    end
  end

  // Saturating stall/flush performance counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count_r <= {CNT_W{1'b0}};
      flush_count_r <= {CNT_W{1'b0}};
    end else begin
      if (freeze_if_s && (stall_count_r != CNT_MAX)) begin
        stall_count_r <= stall_count_r + CNT_ONE;
      end else begin
        stall_count_r <= stall_count_r;
      end
      if (flush_s && (flush_count_r != CNT_MAX)) begin
        flush_count_r <= flush_count_r + CNT_ONE;
      end else begin
        flush_count_r <= flush_count_r;
      end
    end
  end

  // Controls are forced low while reset is held, so an abandoned request drops at once.
  assign bus.sram_req      = sram_req_s    & ~rst;
  assign bus.freeze_IF     = freeze_if_s   & ~rst;
  assign bus.flush_IF_ID   = flush_s       & ~rst;
  assign bus.bubble_ID_EXE = bubble_s      & ~rst;
  assign bus.freeze_pipe   = freeze_pipe_s & ~rst;
  assign bus.mem_timeout   = mem_timeout_r;
  assign bus.stall_count   = stall_count_r;
  assign bus.flush_count   = flush_count_r;
  assign bus.state         = state_r;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed bench for pipeline_stall_controller (CNT_W=4 to reach saturation, TIMEOUT=4).
// Inputs change 1 ns after the rising edge; outputs are sampled 1 ns later.
module tb_pipeline_stall_controller;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  pipeline_stall_controller_if #(.CNT_W(4)) bus ();

  pipeline_stall_controller #(.CNT_W(4), .TIMEOUT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Control vector order: {sram_req, freeze_IF, flush_IF_ID, bubble_ID_EXE, freeze_pipe}
  task automatic chk_ctl(input string tag, input logic [4:0] exp);
    chk(tag, {27'd0, bus.sram_req, bus.freeze_IF, bus.flush_IF_ID, bus.bubble_ID_EXE,
              bus.freeze_pipe}, {27'd0, exp});
  endtask

  task automatic drive(input logic h, input logic b, input logic r, input logic w, input logic rdy);
    bus.hazard_detected = h;
    bus.Branch_taken    = b;
    bus.Mem_R_EN        = r;
    bus.Mem_W_EN        = w;
    bus.sram_ready      = rdy;
    #1;
  endtask

  task automatic next_cyc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    chk_ctl("rst_forced_low", 5'b00000);
    chk("rst_state", {30'd0, bus.state}, 32'd0);
    chk("rst_stall", {28'd0, bus.stall_count}, 32'd0);
    chk("rst_flush", {28'd0, bus.flush_count}, 32'd0);
    chk("rst_timeout", {31'd0, bus.mem_timeout}, 32'd0);
    next_cyc;
    next_cyc;
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_ctl("idle", 5'b00000);
    next_cyc;

    // Hazard only, two cycles
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_ctl("haz_c1", 5'b01010);
    next_cyc;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_ctl("haz_c2", 5'b01010);
    next_cyc;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_ctl("haz_done", 5'b00000);
    chk("haz_stall", {28'd0, bus.stall_count}, 32'd2);
    chk("haz_flush", {28'd0, bus.flush_count}, 32'd0);
    next_cyc;

    // Branch together with hazard: branch wins
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_ctl("br_haz", 5'b00110);
    next_cyc;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("br_flush", {28'd0, bus.flush_count}, 32'd1);
    chk("br_stall", {28'd0, bus.stall_count}, 32'd2);
    next_cyc;

    // Load, ready on the 3rd MEM_WAIT cycle
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk_ctl("ld_run", 5'b01001);
    chk("ld_run_state", {30'd0, bus.state}, 32'd0);
    next_cyc;
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("ld_w1_state", {30'd0, bus.state}, 32'd1);
    chk_ctl("ld_w1", 5'b11001);
    next_cyc;
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk_ctl("ld_w2", 5'b11001);
    next_cyc;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk_ctl("ld_ready", 5'b10000);
    chk("ld_ready_state", {30'd0, bus.state}, 32'd1);
    next_cyc;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("ld_back_state", {30'd0, bus.state}, 32'd0);
    chk_ctl("ld_rdy_ignored", 5'b00000);
    chk("ld_stall", {28'd0, bus.stall_count}, 32'd5);
    next_cyc;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rdy_run_state", {30'd0, bus.state}, 32'd0);
    next_cyc;

    // Branch held during a load: flush only in the ready cycle
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk_ctl("brld_run", 5'b01001);
    next_cyc;
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk_ctl("brld_w1", 5'b11001);
    next_cyc;
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk_ctl("brld_w2", 5'b11001);
    next_cyc;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk_ctl("brld_ready", 5'b10110);
    next_cyc;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_ctl("brld_done", 5'b00000);
    chk("brld_flush", {28'd0, bus.flush_count}, 32'd2);
    chk("brld_stall", {28'd0, bus.stall_count}, 32'd8);
    next_cyc;

    // Back-to-back memory instructions with 1-cycle waits
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk_ctl("b2b_run1", 5'b01001);
    next_cyc;
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk_ctl("b2b_ready1", 5'b10000);
    next_cyc;
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("b2b_run2_state", {30'd0, bus.state}, 32'd0);
    chk_ctl("b2b_run2", 5'b01001);
    next_cyc;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk_ctl("b2b_ready2", 5'b10000);
    next_cyc;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("b2b_state", {30'd0, bus.state}, 32'd0);
    chk("b2b_stall", {28'd0, bus.stall_count}, 32'd10);
    next_cyc;

    // Store that never completes: ABORT after 4 MEM_WAIT cycles
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk_ctl("to_run", 5'b01001);
    next_cyc;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk($sformatf("to_wait%0d_state", i), {30'd0, bus.state}, 32'd1);
      chk_ctl($sformatf("to_wait%0d", i), 5'b11001);
      next_cyc;
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("to_abort_state", {30'd0, bus.state}, 32'd2);
    chk_ctl("to_abort", 5'b01010);
    next_cyc;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("to_back_state", {30'd0, bus.state}, 32'd0);
    chk("to_flag", {31'd0, bus.mem_timeout}, 32'd1);
    chk("to_stall_sat", {28'd0, bus.stall_count}, 32'd15);
    chk_ctl("to_idle", 5'b00000);
    next_cyc;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_ctl("sat_haz", 5'b01010);
    next_cyc;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("sat_hold", {28'd0, bus.stall_count}, 32'd15);
    chk("to_flag_sticky", {31'd0, bus.mem_timeout}, 32'd1);
    next_cyc;

    // Reset in the 2nd MEM_WAIT cycle
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    next_cyc;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_ctl("mr_w1", 5'b11001);
    next_cyc;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_ctl("mr_w2", 5'b11001);
    rst = 1'b1;
    #1;
    chk_ctl("mr_async", 5'b00000);
    chk("mr_state", {30'd0, bus.state}, 32'd0);
    chk("mr_stall", {28'd0, bus.stall_count}, 32'd0);
    chk("mr_flush", {28'd0, bus.flush_count}, 32'd0);
    chk("mr_timeout", {31'd0, bus.mem_timeout}, 32'd0);
    next_cyc;
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("mr_after_state", {30'd0, bus.state}, 32'd0);
    chk_ctl("mr_after", 5'b00000);
    next_cyc;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_stall_controller.md
Name: pipeline_stall_controller

Overview:
- Central stall/flush sequencer for the 5-stage pipeline.
- Combines three event sources into one consistent set of freeze, flush and bubble controls for the IF, ID, EXE, MEM and WB stage registers:
  - hazard_detected from the hazard detection unit;
  - Branch_taken from EXE;
  - SRAM handshake for MEM-stage loads/stores.
- Owns the SRAM request handshake, a wait watchdog and saturating stall/flush performance counters.

Parameters:
- CNT_W, 16, width of stall_count and flush_count.
- TIMEOUT, 64, maximum cycles spent in MEM_WAIT before abort; legal range 2..255.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- hazard_detected  input  1  RAW hazard on the ID-stage sources.
- Branch_taken  input  1  taken branch resolved in EXE this cycle.
- Mem_R_EN  input  1  load in MEM stage.
- Mem_W_EN  input  1  store in MEM stage.
- sram_ready  input  1  SRAM access complete.
- sram_req  output  1  SRAM access request; held until ready or abort.
- freeze_IF  output  1  hold PC and IF/ID register.
- flush_IF_ID  output  1  clear IF/ID register to a NOP.
- bubble_ID_EXE  output  1  clear ID/EXE control bits (WB_EN, MEM_R/W_EN, B, S).
- freeze_pipe  output  1  hold ID/EXE, EXE/MEM and MEM/WB registers.
- mem_timeout  output  1  sticky watchdog flag.
- stall_count  output  CNT_W  cycles with freeze_IF=1.
- flush_count  output  CNT_W  cycles with flush_IF_ID=1.
- state  output  2  debug: 00 RUN, 01 MEM_WAIT, 10 ABORT.

Behaviour:
- Reset, asynchronous:
  - state=RUN, wait_cnt=0, mem_timeout=0, both counters=0.
  - While rst=1, all control outputs are forced to 0.
- Let mem_op = Mem_R_EN | Mem_W_EN.
- State RUN:
  - If mem_op=1: freeze_pipe=1 and freeze_IF=1; flush_IF_ID=0 and bubble_ID_EXE=0. Next state MEM_WAIT, wait_cnt cleared.
  - Else if Branch_taken=1: flush_IF_ID=1 and bubble_ID_EXE=1, freeze_IF=0 so the PC loads the target. Branch overrides hazard because the hazarding instruction is wrong-path.
  - Else if hazard_detected=1: freeze_IF=1 and bubble_ID_EXE=1.
  - Else all controls 0.
  - sram_req=0.
- State MEM_WAIT:
  - sram_req=1.
  - If sram_ready=0: freeze_pipe=1, freeze_IF=1, wait_cnt+1. If wait_cnt==TIMEOUT-1, next state is ABORT.
  - If sram_ready=1: freeze_pipe=0 this cycle, so MEM/WB captures the data and the pipeline advances. Next state RUN.
  - In the ready cycle, the Branch_taken/hazard_detected rules are evaluated exactly as in RUN without mem_op.
  - sram_ready is ignored outside MEM_WAIT. Minimum access latency is therefore 1 wait cycle, 2 cycles total.
- State ABORT, one cycle:
  - mem_timeout set (sticky until reset), sram_req=0.
  - Controls evaluated as the MEM_WAIT ready cycle (pipeline advances, data invalid).
  - Next state RUN.
- Branch or hazard during any frozen cycle:
  - No flush or bubble is issued.
  - Branch_taken is held stable by the frozen EXE register and acts on the first unfrozen cycle.
- Back-to-back memory instructions: each re-enters MEM_WAIT in the RUN cycle after the previous completion. There is no lost or duplicated request.
- Counters:
  - stall_count increments in every cycle with freeze_IF=1.
  - flush_count increments in every cycle with flush_IF_ID=1.
  - Both saturate at all-ones; no wrap.
- Reset mid-access: state returns to RUN and sram_req drops asynchronously. The SRAM side must tolerate an abandoned request.
- Outputs are combinational from the registered state and the current inputs. There are no registered outputs except the counters, mem_timeout and state.

Test Plan:
- Hazard only: hazard_detected=1 for 2 cycles -> freeze_IF=1 and bubble_ID_EXE=1 both cycles; stall_count=2; freeze_pipe=0.
- Branch with hazard: Branch_taken=1 and hazard_detected=1 together -> flush_IF_ID=1, bubble_ID_EXE=1, freeze_IF=0; flush_count=1, stall_count=0.
- Load with 3-cycle SRAM: Mem_R_EN=1, sram_ready asserted on the 3rd MEM_WAIT cycle:
  - freeze_pipe=1 for 3 cycles (RUN plus 2 MEM_WAIT);
  - sram_req=1 for 3 MEM_WAIT cycles;
  - state returns to 00; stall_count=3.
- Branch during memory stall: Branch_taken=1 throughout the load above -> no flush while frozen; flush_IF_ID=1 exactly in the sram_ready cycle.
- Timeout: TIMEOUT=4, sram_ready held 0 -> ABORT entered after 4 MEM_WAIT cycles; mem_timeout=1 and stays 1 after returning to RUN.
- Reset mid-access: rst=1 in the 2nd MEM_WAIT cycle -> sram_req=0 immediately; state=00; counters=0; mem_timeout=0.
